// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg: shared types and constants for the UART bus-master sequencer.
//   state_t      : sequencer FSM states
//   TX_BUSY_BIT  : status-word bit reporting the transmitter is busy
//   RX_FULL_BIT  : status-word bit reporting a received byte is waiting
//   A0_STATUS/A0_DATA : register select values for uart_a0
package uart_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POLL,
        ST_WRITE,
        ST_RXREAD
    } state_t;

    localparam int unsigned TX_BUSY_BIT = 15;
    localparam int unsigned RX_FULL_BIT = 14;

    localparam logic A0_STATUS = 1'b0;
    localparam logic A0_DATA   = 1'b1;

endpackage

// File: rtl/uart_rr_arb2.sv
// uart_rr_arb2: two-way round-robin arbiter, purely combinational.
//   req[1:0]   in  : request lines
//   last_grant in  : index of the requester granted most recently
//   grant[1:0] out : one-hot grant (all zero when nothing requests)
module uart_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        // On a tie the requester that did not win last time is served.
        if (req[0] && (!req[1] || last_grant)) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_seq.sv
// uart_seq: bus-master sequencer sharing a memory-mapped UART between two
// byte-stream requesters. Polls the UART status word, writes a data byte only
// when the transmitter is idle (round-robin between requesters) and, when
// built with UART_SEQ_RX_EN, drains received bytes into a holding register.
//   clk, reset             : clock, synchronous active-high reset
//   reqN_valid/data/ready  : requester byte streams (ready is a 1-cycle pulse)
//   rx_data/valid/ready    : received-byte handshake (UART_SEQ_RX_EN only)
//   uart_cs_b/rnw/a0       : UART bus control (Moore-decoded from state)
//   uart_dout / uart_din   : UART write / read data
// Optional feature macro: UART_SEQ_RX_EN.
module uart_seq
    import uart_seq_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        uart_cs_b,
    output logic        uart_rnw,
    output logic        uart_a0,
    output logic [15:0] uart_dout,
    input  logic [15:0] uart_din
);

    localparam logic [7:0] WAIT_LAST = 8'(POLL_INTERVAL - 1);

    state_t      state, state_nx;
    logic [7:0]  wait_cnt;
    logic        last_grant;
    logic        grant_q;
    logic [1:0]  grant;
    logic        rx_take;
    logic        tx_busy;
    logic        unused_din;

    assign tx_busy = uart_din[TX_BUSY_BIT];

    uart_rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef UART_SEQ_RX_EN
    logic       rx_valid_q;
    logic [7:0] rx_data_q;

    // Read only when the holding register is free or is emptied on this edge.
    assign rx_take = uart_din[RX_FULL_BIT] && (!rx_valid_q || rx_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else if (state == ST_RXREAD) begin
            rx_data_q  <= uart_din[7:0];
            rx_valid_q <= 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign unused_din = ^uart_din[13:8];
`else
    assign rx_take    = 1'b0;
    assign rx_valid   = 1'b0;
    assign rx_data    = '0;
    assign unused_din = ^{uart_din[14:0], rx_ready};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) begin
                wait_cnt <= (wait_cnt == WAIT_LAST) ? '0 : wait_cnt + 8'd1;
            end
            if (state == ST_POLL && state_nx == ST_WRITE) begin
                grant_q <= grant[1];
            end
            if (state == ST_WRITE) begin
                last_grant <= grant_q;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (wait_cnt == WAIT_LAST) state_nx = ST_POLL;
            end
            ST_POLL: begin
                if (rx_take)                                 state_nx = ST_RXREAD;
                else if (!tx_busy && (req0_valid || req1_valid)) state_nx = ST_WRITE;
                else                                         state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_cs_b  = 1'b1;
        uart_rnw   = 1'b1;
        uart_a0    = A0_STATUS;
        uart_dout  = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_POLL: begin
                uart_cs_b = 1'b0;
            end
            ST_WRITE: begin
                uart_cs_b  = 1'b0;
                uart_rnw   = 1'b0;
                uart_a0    = A0_DATA;
                uart_dout  = {8'h00, grant_q ? req1_data : req0_data};
                req0_ready = !grant_q;
                req1_ready = grant_q;
            end
            ST_RXREAD: begin
                uart_cs_b = 1'b0;
                uart_a0   = A0_DATA;
            end
            default: ;
        endcase
        // Abandon any in-flight transaction immediately while reset is high.
        if (reset) begin
            uart_cs_b  = 1'b1;
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_seq.sv
// tb_uart_seq: self-checking bench for uart_seq with a behavioural UART model.
module tb_uart_seq;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        uart_cs_b, uart_rnw, uart_a0;
    logic [15:0] uart_dout, uart_din;

    int n_cmp = 0;
    int n_err = 0;

    // UART model state
    logic        force_en;
    logic [15:0] force_din;
    int          m_busy;
    int          busy_len;
    logic        m_rx_full;
    logic [7:0]  m_rx_byte;
    int          rd_count;
    logic [7:0]  wr_log[$];
    int          wr_cyc[$];
    int          cyc;
    logic        p_wr, p_rd, p_poll;
    logic [7:0]  p_byte;
    logic [7:0]  rx_exp[$];

    assign uart_din = force_en ? force_din :
                      (uart_a0 ? {8'h00, m_rx_byte} : {(m_busy != 0), m_rx_full, 14'h0});

    uart_seq #(.POLL_INTERVAL(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .uart_cs_b  (uart_cs_b),
        .uart_rnw   (uart_rnw),
        .uart_a0    (uart_a0),
        .uart_dout  (uart_dout),
        .uart_din   (uart_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample();
        p_wr   = !uart_cs_b && !uart_rnw;
        p_rd   = !uart_cs_b && uart_rnw && uart_a0;
        p_poll = !uart_cs_b && uart_rnw && !uart_a0;
        p_byte = uart_dout[7:0];
    endtask

    // Advance one clock: apply the UART effects of the cycle that just ended,
    // then capture the bus operation of the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (p_wr) begin
            m_busy = busy_len;
            wr_log.push_back(p_byte);
            wr_cyc.push_back(cyc - 1);
        end else if (m_busy != 0) begin
            m_busy--;
        end
        if (p_rd) begin
            m_rx_full = 1'b0;
            rd_count++;
        end
        sample();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        reset     = 1'b0;
        m_busy    = 0;
        m_rx_full = 1'b0;
        rd_count  = 0;
        wr_log.delete();
        wr_cyc.delete();
        rx_exp.delete();
        p_wr = 1'b0; p_rd = 1'b0; p_poll = 1'b0;
    endtask

    typedef struct {
        logic [15:0] status;
        logic        r0v;
        logic [7:0]  r0d;
        logic        r1v;
        logic [7:0]  r1d;
        logic        e_cs_b;
        logic        e_rnw;
        logic        e_a0;
        logic [15:0] e_dout;
        logic        e_r0;
        logic        e_r1;
    } vec_t;

    vec_t vecs[7];

    // random-test state
    int   last_idx;
    logic pv0, pv1;
    logic done0, done1;

    task automatic rand_step(input bit gen);
        int idx, exp_idx;
        tick();
        if (done0) begin req0_valid = 1'b0; done0 = 1'b0; end
        if (done1) begin req1_valid = 1'b0; done1 = 1'b0; end
        if (gen && !req0_valid && $urandom_range(0, 3) == 0) begin
            req0_valid = 1'b1; req0_data = 8'($urandom);
        end
        if (gen && !req1_valid && $urandom_range(0, 3) == 0) begin
            req1_valid = 1'b1; req1_data = 8'($urandom);
        end
        busy_len = gen ? $urandom_range(0, 6) : 0;
        if (p_poll) begin pv0 = req0_valid; pv1 = req1_valid; end
        if (p_wr) begin
            idx     = req1_ready ? 1 : 0;
            exp_idx = (pv0 && pv1) ? (1 - last_idx) : (pv1 ? 1 : 0);
            chk("rnd_one_ready", 32'(req0_ready ^ req1_ready), 1);
            chk("rnd_tx_idle_at_write", m_busy, 0);
            chk("rnd_grant", idx, exp_idx);
            chk("rnd_wr_data", uart_dout, {8'h00, (idx == 1) ? req1_data : req0_data});
            last_idx = idx;
            if (idx == 1) done1 = 1'b1; else done0 = 1'b1;
        end else begin
            chk("rnd_ready_without_write", {req0_ready, req1_ready}, 0);
        end
        if (gen && !m_rx_full && $urandom_range(0, 7) == 0) begin
            m_rx_full = 1'b1;
            m_rx_byte = 8'($urandom);
`ifdef UART_SEQ_RX_EN
            rx_exp.push_back(m_rx_byte);
`endif
        end
`ifdef UART_SEQ_RX_EN
        rx_ready = gen ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rx_valid && rx_ready) begin
            chk("rnd_rx_data", rx_data, (rx_exp.size() != 0) ? 32'(rx_exp.pop_front()) : 32'hDEAD);
        end
`else
        rx_ready = 1'($urandom_range(0, 1));
        chk("rnd_rx_valid_off", rx_valid, 0);
`endif
    endtask

    initial begin
        int base, polls, poll5, wr_first, rdy_first, rd_first, nrdy;
        logic drop;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        rx_ready = 1'b0;
        force_en = 1'b0; force_din = '0;
        m_busy = 0; busy_len = 0; m_rx_full = 1'b0; m_rx_byte = '0;
        rd_count = 0; cyc = 0;
        p_wr = 1'b0; p_rd = 1'b0; p_poll = 1'b0; p_byte = '0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            req0_data = 8'($urandom); req1_data = 8'($urandom);
            rx_ready = 1'($urandom);
            force_en = 1'b1; force_din = 16'($urandom);
            tick();
            chk("rst_cs_b", uart_cs_b, 1);
            chk("rst_rnw", uart_rnw, 1);
            chk("rst_ready", {req0_ready, req1_ready}, 0);
            chk("rst_rx_valid", rx_valid, 0);
        end
        chk("rst_dout", uart_dout, 0);
        chk("rst_a0", uart_a0, 0);
        req0_valid = 1'b0; req1_valid = 1'b0; rx_ready = 1'b0; force_en = 1'b0;

        // Single-round table vectors from reset
        vecs[0] = '{16'h0000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0041, 1'b1, 1'b0};
        vecs[1] = '{16'h0000, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 16'h0033, 1'b0, 1'b1};
        vecs[2] = '{16'h0000, 1'b1, 8'h55, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
`ifdef UART_SEQ_RX_EN
        vecs[5] = '{16'h4000, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{16'hC000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
`else
        vecs[5] = '{16'h4000, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 16'h0033, 1'b0, 1'b1};
        vecs[6] = '{16'hC000, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 7; i++) begin
            do_reset(2);
            force_en = 1'b1; force_din = vecs[i].status;
            req0_valid = vecs[i].r0v; req0_data = vecs[i].r0d;
            req1_valid = vecs[i].r1v; req1_data = vecs[i].r1d;
            tick();
            chk($sformatf("vec%0d_poll_bus", i), {uart_cs_b, uart_rnw, uart_a0}, 3'b010);
            tick();
            chk($sformatf("vec%0d_bus", i), {uart_cs_b, uart_rnw, uart_a0},
                {vecs[i].e_cs_b, vecs[i].e_rnw, vecs[i].e_a0});
            chk($sformatf("vec%0d_dout", i), uart_dout, vecs[i].e_dout);
            chk($sformatf("vec%0d_ready", i), {req0_ready, req1_ready}, {vecs[i].e_r0, vecs[i].e_r1});
            tick();
            chk($sformatf("vec%0d_ready_pulse", i), {req0_ready, req1_ready}, 0);
        end
        force_en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // Both requesters held, UART idle: strict alternation
        do_reset(2);
        busy_len = 0;
        req0_valid = 1'b1; req0_data = 8'h55;
        req1_valid = 1'b1; req1_data = 8'hAA;
        for (int k = 0; k < 40 && wr_log.size() < 4; k++) tick();
        chk("rr_count", wr_log.size(), 4);
        if (wr_log.size() >= 4) begin
            chk("rr_w0", wr_log[0], 8'h55);
            chk("rr_w1", wr_log[1], 8'hAA);
            chk("rr_w2", wr_log[2], 8'h55);
            chk("rr_w3", wr_log[3], 8'hAA);
            chk("rr_gap_ok", 32'((wr_cyc[1] - wr_cyc[0]) >= 3 && (wr_cyc[3] - wr_cyc[2]) >= 3), 1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // tx_busy for four polls, then clear
        do_reset(2);
        force_en = 1'b1; force_din = 16'h8000;
        req0_valid = 1'b1; req0_data = 8'h21;
        polls = 0; poll5 = -1; wr_first = -1; rdy_first = -1;
        for (int k = 0; k < 60 && wr_first < 0; k++) begin
            tick();
            if (p_poll) begin
                polls++;
                if (polls == 5) poll5 = cyc;
            end
            if ((req0_ready || req1_ready) && rdy_first < 0) rdy_first = cyc;
            if (p_wr && wr_first < 0) wr_first = cyc;
            force_din = (polls >= 5) ? 16'h0000 : 16'h8000;
        end
        chk("busy_first_write_cycle", wr_first, poll5 + 1);
        chk("busy_first_ready_cycle", rdy_first, poll5 + 1);
        force_en = 1'b0; req0_valid = 1'b0;

        // Reset asserted during WRITE: abandoned, byte retried later
        do_reset(2);
        busy_len = 0;
        req0_valid = 1'b1; req0_data = 8'h12;
        tick();
        tick();
        chk("midrst_in_write", p_wr, 1);
        reset = 1'b1;
        #1;
        chk("midrst_cs_b", uart_cs_b, 1);
        chk("midrst_ready", {req0_ready, req1_ready}, 0);
        sample();
        tick();
        reset = 1'b0;
        wr_log.delete();
        nrdy = 0; drop = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (drop) begin req0_valid = 1'b0; drop = 1'b0; end
            if (req0_ready) begin nrdy++; drop = 1'b1; end
        end
        chk("midrst_retry_ready_count", nrdy, 1);
        chk("midrst_retry_writes", wr_log.size(), 1);
        if (wr_log.size() != 0) chk("midrst_retry_byte", wr_log[0], 8'h12);
        req0_valid = 1'b0;

`ifdef UART_SEQ_RX_EN
        // Holding register blocks further reads until consumed
        do_reset(2);
        m_rx_full = 1'b1; m_rx_byte = 8'h7E; rx_ready = 1'b0;
        for (int k = 0; k < 20 && rd_count < 1; k++) tick();
        chk("rx_first_valid", rx_valid, 1);
        chk("rx_first_data", rx_data, 8'h7E);
        m_rx_full = 1'b1; m_rx_byte = 8'h9C;
        for (int k = 0; k < 20; k++) tick();
        chk("rx_hold_reads", rd_count, 1);
        chk("rx_hold_valid", rx_valid, 1);
        chk("rx_hold_data", rx_data, 8'h7E);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        for (int k = 0; k < 20 && rd_count < 2; k++) tick();
        chk("rx_second_reads", rd_count, 2);
        chk("rx_second_data", rx_data, 8'h9C);
        chk("rx_second_valid", rx_valid, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
`endif

        // RX full and req1 in the same poll
        do_reset(2);
        base = cyc;
        busy_len = 0;
        m_rx_full = 1'b1; m_rx_byte = 8'h5A;
        req1_valid = 1'b1; req1_data = 8'h33;
        rd_first = -1; wr_first = -1; drop = 1'b0;
        for (int k = 0; k < 20 && wr_first < 0; k++) begin
            tick();
            if (drop) begin req1_valid = 1'b0; drop = 1'b0; end
            if (p_rd && rd_first < 0) rd_first = cyc;
            if (p_wr && wr_first < 0) begin wr_first = cyc; drop = 1'b1; end
        end
        tick();
        req1_valid = 1'b0;
`ifdef UART_SEQ_RX_EN
        chk("rxw_read_cycle", rd_first, base + 2);
        chk("rxw_write_cycle", wr_first, base + 5);
`else
        chk("rxw_write_cycle", wr_first, base + 2);
        chk("rxw_no_read", rd_count, 0);
`endif
        chk("rxw_write_byte", (wr_log.size() != 0) ? 32'(wr_log[0]) : 32'hDEAD, 8'h33);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;

        // Randomized traffic against the reference rules
        do_reset(2);
        last_idx = 1; pv0 = 1'b0; pv1 = 1'b0; done0 = 1'b0; done1 = 1'b0;
        for (int k = 0; k < 3000; k++) rand_step(1'b1);
        for (int k = 0; k < 300; k++) rand_step(1'b0);
        chk("drain_req0", req0_valid, 0);
        chk("drain_req1", req1_valid, 0);
`ifdef UART_SEQ_RX_EN
        chk("drain_rx_expected", rx_exp.size(), 0);
        chk("drain_rx_valid", rx_valid, 0);
        chk("drain_uart_rx_full", m_rx_full, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
